// File: rtl/lut_ram_fifo_ctrl.sv
// Synchronous FIFO controller driving an external lut_ram.
// Owns pointers, occupancy and flags; the RAM holds the data.
module lut_ram_fifo_ctrl #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 256,
    parameter int AFULL_LVL = DEPTH - 4,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WIDTH-1:0]  s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WIDTH-1:0]  m_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [WIDTH-1:0]  ram_wr_data,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [WIDTH-1:0]  ram_rd_data
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_AF   = (ADDR_W + 1)'(AFULL_LVL);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);

    // Ready ignores a same-cycle pop so the full path stays registered-only
    assign s_ready = ~w_full & ~flush & ~rst;
    assign m_valid = ~w_empty & ~flush;
    assign w_push  = s_valid & s_ready;
    assign w_pop   = m_valid & m_ready;

    assign ram_wr_en   = w_push;
    assign ram_wr_addr = r_wr_ptr;
    assign ram_wr_data = s_data;
    assign ram_rd_addr = r_rd_ptr;
    assign m_data      = ram_rd_data;

    assign count       = r_count;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (r_count >= CNT_AF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + ADDR_W'(1);
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + ADDR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_ram_fifo_ctrl.sv
// Scoreboard bench for lut_ram_fifo_ctrl with a behavioural RAM
// and a queue-based reference model of FIFO contents.
module tb_lut_ram_fifo_ctrl;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 256;
    localparam int AFULL  = DEPTH - 4;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              s_valid;
    logic              s_ready;
    logic [WIDTH-1:0]  s_data;
    logic              m_valid;
    logic              m_ready;
    logic [WIDTH-1:0]  m_data;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [WIDTH-1:0]  ram_wr_data;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [WIDTH-1:0]  ram_rd_data;

    logic [WIDTH-1:0] mem [DEPTH];

    int checks = 0;
    int failures = 0;
    logic [WIDTH-1:0] exp_q[$];
    int wr_idx = 0;

    always #5 clk = ~clk;

    lut_ram_fifo_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LVL(AFULL)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count), .full(full), .empty(empty),
        .almost_full(almost_full),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data)
    );

    always @(posedge clk)
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    assign ram_rd_data = mem[ram_rd_addr];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor: model state is the queue of words in flight
    always @(negedge clk) begin
        int n;
        if (rst) begin
            exp_q.delete();
            wr_idx = 0;
        end
        n = exp_q.size();
        chk("count", 64'(count), 64'(n));
        chk("empty", 64'(empty), 64'(n == 0));
        chk("full", 64'(full), 64'(n == DEPTH));
        chk("almost_full", 64'(almost_full), 64'(n >= AFULL));
        chk("s_ready", 64'(s_ready), 64'(n != DEPTH && !flush && !rst));
        chk("m_valid", 64'(m_valid), 64'(n != 0 && !flush));
        chk("ram_wr_en", 64'(ram_wr_en), 64'(s_valid && n != DEPTH && !flush && !rst));
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0)
                chk("pop_underflow", 64'(1), 64'(0));
            else
                chk("m_data", 64'(m_data), 64'(exp_q.pop_front()));
        end
        if (s_valid && s_ready) begin
            chk("wr_addr", 64'(ram_wr_addr), 64'(wr_idx % DEPTH));
            chk("wr_data", 64'(ram_wr_data), 64'(s_data));
            exp_q.push_back(s_data);
            wr_idx++;
        end
        if (flush && !rst) begin
            exp_q.delete();
            wr_idx = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d);
        int n;
        bit acc;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        do begin
            @(negedge clk);
            acc = s_ready;
            step();
            n++;
        end while (!acc && n < 1000);
        chk("push_timeout", 64'(acc), 64'(1));
        s_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (empty) done = 1'b1;
            else step();
        end
        chk("drain_timeout", 64'(done), 64'(1));
        step();
        m_ready = 1'b0;
    endtask

    initial begin
        int pushes;
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0;
        m_ready = 1'b0; s_data = '0;
        step(); step();
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", 64'(s_ready), 64'(1));
        step();

        // Fill to full, then try pushing while popping
        for (int i = 1; i <= DEPTH; i++) push_word(32'(i));
        @(negedge clk);
        chk("fill_full", 64'(full), 64'(1));
        chk("fill_s_ready", 64'(s_ready), 64'(0));
        chk("fill_head", 64'(m_data), 64'(1));
        step();
        s_valid = 1'b1; s_data = 32'h1234_5678; m_ready = 1'b1;
        step();
        s_valid = 1'b0; m_ready = 1'b0;
        chk("full_push_pop_count", 64'(count), 64'(DEPTH - 1));
        drain();

        // Fall-through latency
        s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
        step();
        s_valid = 1'b0;
        @(negedge clk);
        chk("lat_m_valid", 64'(m_valid), 64'(1));
        chk("lat_m_data", 64'(m_data), 64'hDEAD_BEEF);
        step();
        drain();

        // Steady push+pop at count 10
        for (int i = 0; i < 10; i++) push_word($urandom);
        s_valid = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_data = $urandom;
            step();
            chk("steady_count", 64'(count), 64'(10));
        end
        s_valid = 1'b0; m_ready = 1'b0;
        drain();

        // Random interleave, 300 pushes, pointers wrap
        pushes = 0;
        for (int c = 0; c < 5000 && pushes < 300; c++) begin
            s_valid = 1'($urandom);
            s_data  = $urandom;
            m_ready = 1'($urandom);
            @(negedge clk);
            if (s_valid && s_ready) pushes++;
            step();
        end
        chk("wrap_pushes", 64'(pushes), 64'(300));
        s_valid = 1'b0;
        drain();

        // Flush with 7 entries while a word is offered
        for (int i = 0; i < 7; i++) push_word($urandom);
        flush = 1'b1; s_valid = 1'b1; s_data = 32'hFFFF_0000;
        @(negedge clk);
        chk("flush_no_wr", 64'(ram_wr_en), 64'(0));
        step();
        flush = 1'b0; s_valid = 1'b0;
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_empty", 64'(empty), 64'(1));
        push_word(32'hA5A5_A5A5);
        @(negedge clk);
        chk("flush_readback", 64'(m_data), 64'hA5A5_A5A5);
        step();
        drain();

        // Asynchronous reset mid-cycle with 5 entries
        for (int i = 0; i < 5; i++) push_word($urandom);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_count", 64'(count), 64'(0));
        chk("arst_empty", 64'(empty), 64'(1));
        chk("arst_s_ready", 64'(s_ready), 64'(0));
        chk("arst_m_valid", 64'(m_valid), 64'(0));
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("arst_rel_s_ready", 64'(s_ready), 64'(1));
        chk("arst_rel_m_valid", 64'(m_valid), 64'(0));
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
